// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: BOOT/RUN/WAIT_MEM sequencing, redirect buffering, delay-slot aware.
// Optional performance counters are enabled by defining PC_FETCH_PERF_CNT_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        is_branch,
    input  logic [31:0] branch_pc,
    input  logic        exc_req,
    input  logic [31:0] exc_vector,
    input  logic        imem_ready,
    output logic [31:0] pc_out,
    output logic        imem_req,
    output logic        if_valid,
    output logic        redirect_pending
`ifdef PC_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_WAIT_MEM
    } state_t;

    state_t      r_state;
    logic        r_imem_req;
    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic        r_pend_exc;
    logic [31:0] r_pend_pc;

    logic        w_adv;
    logic        w_non_seq;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;

    assign w_adv = r_imem_req & imem_ready & ~stall;

    // Pending exception and pending branch share one buffer, so "pending" covers both priorities.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_target  = r_pc + 32'd4;
        w_non_seq = 1'b0;
        if (exc_req) begin
            w_target  = exc_vector;
            w_non_seq = 1'b1;
        end else if (r_pend_valid) begin
            w_target  = r_pend_pc;
            w_non_seq = 1'b1;
        end else if (is_branch) begin
            w_target  = branch_pc;
            w_non_seq = 1'b1;
        end
    end

    assign w_next_pc = w_target & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_imem_req <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state    <= S_RUN;
                    r_imem_req <= 1'b1;
                end
                S_RUN: begin
                    r_imem_req <= 1'b1;
                    if (r_imem_req && !imem_ready)
                        r_state <= S_WAIT_MEM;
                end
                S_WAIT_MEM: begin
                    r_imem_req <= 1'b1;
                    if (imem_ready)
                        r_state <= S_RUN;
                end
                default: begin
                    r_state    <= S_BOOT;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // A held stall or memory wait buffers the redirect; an exception overrides a buffered branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_exc   <= 1'b0;
            r_pend_pc    <= 32'h0;
        end else if (w_adv) begin
            r_pc         <= w_next_pc;
            r_pend_valid <= 1'b0;
            r_pend_exc   <= 1'b0;
        end else if (exc_req) begin
            r_pend_valid <= 1'b1;
            r_pend_exc   <= 1'b1;
            r_pend_pc    <= exc_vector;
        end else if (is_branch && !(r_pend_valid && r_pend_exc)) begin
            r_pend_valid <= 1'b1;
            r_pend_exc   <= 1'b0;
            r_pend_pc    <= branch_pc;
        end
    end

    assign pc_out           = r_pc;
    assign imem_req         = r_imem_req;
    assign redirect_pending = r_pend_valid;
    assign if_valid         = (r_state != S_BOOT) & imem_ready & ~exc_req
                              & ~(r_pend_valid & r_pend_exc);

`ifdef PC_FETCH_PERF_CNT_EN
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_redirect_cnt <= 32'h0;
            r_stall_cnt    <= 32'h0;
        end else begin
            if (w_adv && w_non_seq)
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            if ((r_state != S_BOOT) && !w_adv)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign stall_cnt    = r_stall_cnt;
`else
    logic w_unused;
    assign w_unused = w_non_seq;
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port stall, input, 1, hazard-unit hold request; when high, the PC does not advance.
REQ-005 SHALL have port is_branch, input, 1, ID-stage branch/jump taken indication.
REQ-006 SHALL have port branch_pc, input, 32, ID-stage redirect target, computed relative to pc_out.
REQ-007 SHALL have port exc_req, input, 1, exception/eret redirect request.
REQ-008 SHALL have port exc_vector, input, 32, exception/eret target.
REQ-009 SHALL have port imem_ready, input, 1, instruction memory has returned the word at pc_out this cycle.
REQ-010 SHALL have port pc_out, output, 32, current fetch PC, also the delay-slot PC fed to the branch unit.
REQ-011 SHALL have port imem_req, output, 1, fetch request for pc_out.
REQ-012 SHALL have port if_valid, output, 1, fetched word is a live instruction for IF/ID.
REQ-013 SHALL have port redirect_pending, output, 1, a redirect is buffered and not yet applied.

Function
REQ-014 SHALL implement FSM states BOOT, RUN and WAIT_MEM.
REQ-015 BOOT SHALL drive imem_req=0 and if_valid=0, and SHALL go to RUN after exactly one cycle.
REQ-016 RUN SHALL drive imem_req=1; with imem_req=1 and imem_ready=0 the FSM SHALL go to WAIT_MEM.
REQ-017 WAIT_MEM SHALL keep imem_req=1 and hold pc_out, and SHALL return to RUN in the cycle after imem_ready=1.
REQ-018 The advance condition SHALL be adv = imem_req & imem_ready & ~stall; pc_out SHALL update only when adv=1.
REQ-019 Next-PC priority SHALL be: exc_req, then pending exception, then pending branch, then is_branch, then pc_out+4.
REQ-020 pc_out+4 SHALL wrap modulo 2^32.
REQ-021 Every target SHALL have bits [1:0] forced to 2'b00 before loading, so pc_out[1:0]=00 at all times.
REQ-022 When adv=0 and exc_req=1, the block SHALL capture exc_vector into the pending register and mark it as an exception, overwriting any pending branch.
REQ-023 When adv=0, is_branch=1, exc_req=0 and no exception is pending, the block SHALL capture branch_pc as a pending branch.
REQ-024 A repeated is_branch during a held stall SHALL rewrite the pending branch with the same target, with no side effects.
REQ-025 redirect_pending SHALL equal the pending-valid flag, and SHALL clear on the adv cycle that consumes the pending redirect.
REQ-026 A branch SHALL NOT kill the delay slot.
REQ-027 if_valid SHALL be (state==RUN or WAIT_MEM) & imem_ready & ~exc_req & ~(pending valid & pending is exception).
REQ-028 With if_valid=1, the word at pc_out is the live instruction.
REQ-029 Simultaneous is_branch and exc_req SHALL select the exception target.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL take: state=BOOT, pc_out=RESET_PC, pending cleared, imem_req=0, if_valid=0, redirect_pending=0.
REQ-031 Reset asserted mid-WAIT_MEM or with a redirect pending SHALL discard all in-flight state; no pending target survives reset.

Configuration
REQ-032 Macro PC_FETCH_PERF_CNT_EN, when defined, SHALL add output redirect_cnt (32 bits) and output stall_cnt (32 bits).
REQ-033 With the macro defined, redirect_cnt SHALL increment on each adv cycle that loads a non-sequential target.
REQ-034 With the macro defined, stall_cnt SHALL increment on each RUN/WAIT_MEM cycle with adv=0.
REQ-035 With the macro defined, both counters SHALL wrap modulo 2^32 and reset to 0.
REQ-036 Without the macro, these ports and this logic SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-037 Reset release, imem_ready=1, no stall -> BOOT one cycle; then pc_out sequence 0x00400000, 0x00400004, 0x00400008; if_valid=1 from the first RUN cycle.
REQ-038 At pc_out=0x00400008, is_branch=1 with branch_pc=0x00400100 -> next pc_out=0x00400100; the delay-slot word reports if_valid=1.
REQ-039 stall=1 for 3 cycles with is_branch=1 and branch_pc=0x00400200 -> pc_out held and redirect_pending=1; on the first cycle with stall=0, pc_out becomes 0x00400200 and redirect_pending=0.
REQ-040 imem_ready=0 for 2 cycles with exc_req=1 and exc_vector=0x80000183 -> WAIT_MEM, if_valid=0; after imem_ready=1, pc_out=0x80000180 and the killed word reports if_valid=0.
REQ-041 pc_out=0xFFFFFFFC with sequential advance -> pc_out=0x00000000.
REQ-042 rst_n=0 asserted while redirect_pending=1 -> pc_out=RESET_PC, redirect_pending=0, and no later redirect occurs.
